// File: rtl/mem_stream_reader_pkg.sv
// Shared definitions for the memory stream reader: parameter defaults and
// the controller state encoding.
package mem_stream_reader_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } msr_state_t;

endpackage

// File: rtl/mem_stream_reader_if.sv
// Bus bundle for the stream reader: synchronous memory read port plus the
// valid/ready output stream. The reader is the master, memory/consumer the slave.
interface mem_stream_reader_if
    import mem_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
);

    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] data_out;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output mem_rd, mem_addr, data_out, out_valid,
        input  mem_data, out_ready
    );

    modport slave (
        input  mem_rd, mem_addr, data_out, out_valid,
        output mem_data, out_ready
    );

endinterface

// File: rtl/msr_out_buf.sv
// Two-entry FIFO between the memory read port and the output stream.
// The head entry is presented directly on out_data, so it stays stable while
// the consumer stalls.
module msr_out_buf #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              full,
    output logic              empty
);

    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [1:0] count_reg;
    logic       pop;

    assign pop       = out_valid & out_ready;
    assign out_valid = (count_reg != 2'd0);
    assign empty     = (count_reg == 2'd0);
    assign full      = (count_reg == 2'd2);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_W-1:0] entry_reg;
            // Capture pushed data into the slot addressed by the write pointer.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    entry_reg <= push_data;
                end
            end
        end
    endgenerate

    assign out_data = rd_ptr_reg ? g_entry[1].entry_reg : g_entry[0].entry_reg;

    // Pointer and occupancy bookkeeping; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 2'd1;
                2'b01:   count_reg <= count_reg - 2'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Burst reader: streams `length` words from a synchronous memory starting at
// base_addr (address wraps) onto a valid/ready stream through a 2-entry buffer.
// Optional feature macro: MEM_STREAM_READER_STAT_EN adds a saturating
// 16-bit word_count output counting stream transfers since reset.
module mem_stream_reader
    import mem_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
`ifdef MEM_STREAM_READER_STAT_EN
    output logic [15:0]       word_count,
`endif
    mem_stream_reader_if.master bus
);

    localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    msr_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic [ADDR_W:0]   rd_left_reg, rd_left_next;
    logic [ADDR_W:0]   words_left_reg, words_left_next;
    logic              inflight_reg;
    logic              done_reg, done_next;
    logic              rd_issue;

    logic              buf_valid;
    logic [DATA_W-1:0] buf_data;
    logic              buf_full;
    logic              buf_empty;
    logic              pop;
    logic [2:0]        occ;
    logic [2:0]        level;

    // The read issued last cycle lands in the buffer this cycle.
    msr_out_buf #(.DATA_W(DATA_W)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (inflight_reg),
        .push_data (bus.mem_data),
        .out_ready (bus.out_ready),
        .out_valid (buf_valid),
        .out_data  (buf_data),
        .full      (buf_full),
        .empty     (buf_empty)
    );

    assign pop           = buf_valid & bus.out_ready;
    assign bus.out_valid = buf_valid;
    assign bus.data_out  = buf_data;
    assign bus.mem_rd    = rd_issue;
    assign bus.mem_addr  = addr_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;

    // Words committed to the buffer (held + in flight) net of the word leaving
    // this cycle; counting the pop keeps one read per cycle at full throughput.
    assign occ   = buf_full ? 3'd2 : (buf_empty ? 3'd0 : 3'd1);
    assign level = occ + {2'b00, inflight_reg} - {2'b00, pop};

    // Next-state logic: burst capture, read issue with address wrap, drain to done.
    always_comb begin
        state_next      = state_reg;
        addr_next       = addr_reg;
        rd_left_next    = rd_left_reg;
        words_left_next = words_left_reg;
        done_next       = 1'b0;
        rd_issue        = 1'b0;

        if (pop) begin
            words_left_next = words_left_reg - CNT_ONE;
        end

        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (length == '0) begin
                        done_next = 1'b1;
                    end else begin
                        state_next      = ST_READ;
                        addr_next       = base_addr;
                        rd_left_next    = length;
                        words_left_next = length;
                    end
                end
            end
            ST_READ: begin
                rd_issue = (level < 3'd2);
                if (rd_issue) begin
                    addr_next    = addr_reg + ADDR_ONE;
                    rd_left_next = rd_left_reg - CNT_ONE;
                    if (rd_left_reg == CNT_ONE) begin
                        state_next = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && (words_left_reg == CNT_ONE)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Controller registers; reset drops any in-flight read so its data is never pushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            addr_reg       <= '0;
            rd_left_reg    <= '0;
            words_left_reg <= '0;
            inflight_reg   <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            addr_reg       <= addr_next;
            rd_left_reg    <= rd_left_next;
            words_left_reg <= words_left_next;
            inflight_reg   <= rd_issue;
            done_reg       <= done_next;
        end
    end

`ifdef MEM_STREAM_READER_STAT_EN
    logic [15:0] word_count_reg;

    // Saturating count of stream transfers since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_reg <= 16'h0000;
        end else if (pop && (word_count_reg != 16'hFFFF)) begin
            word_count_reg <= word_count_reg + 16'h0001;
        end
    end

    assign word_count = word_count_reg;
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Directed bench for mem_stream_reader: a table of bursts with hand-computed
// timing, plus hand-written sequences for restart-in-done, start-while-busy
// and mid-burst reset.
module tb_mem_stream_reader;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
`ifdef MEM_STREAM_READER_STAT_EN
    logic [15:0]   word_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mem_stream_reader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    mem_stream_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_addr  (base_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
`ifdef MEM_STREAM_READER_STAT_EN
        .word_count (word_count),
`endif
        .bus        (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] word_of(int a);
        return 8'(((a % 16) * 37) + 11);
    endfunction

    // Synchronous memory: data one cycle after the strobe, a marker value otherwise.
    always @(posedge clk) begin
        bus.mem_data <= bus.mem_rd ? word_of(int'(bus.mem_addr)) : 8'hEE;
    end

    function automatic logic ready_for(int mode, int c);
        if (mode == 1) return (c % 2) == 1;
        if (mode == 2) return c >= 5;
        return 1'b1;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        int base;
        int len;
        int mode;
        int restart_c;
        int exp_first;
        int exp_done;
    } vec_t;

    vec_t vecs[7];

    // One burst from cycle 0 (start) until two cycles after done; checks every cycle.
    task automatic run_burst(input vec_t v, input string nm);
        int c, reads, xfers, first_rd, first_val, done_c, done_n, last_xfer;
        int addr_err, data_err, stall_err, space_err, busy_err;
        logic prev_stall, xfer, exp_busy;
        logic [7:0] prev_data;
        logic busy_hist[200];
        reads = 0; xfers = 0; first_rd = -1; first_val = -1; done_c = -1;
        done_n = 0; last_xfer = -1; addr_err = 0; data_err = 0; stall_err = 0;
        space_err = 0; busy_err = 0; prev_stall = 1'b0; prev_data = '0;
        @(posedge clk);
        #1;
        c = 0;
        start = 1'b1;
        base_addr = AW'(v.base);
        length = (AW + 1)'(v.len);
        bus.out_ready = ready_for(v.mode, 0);
        while (1) begin
            @(negedge clk);
            busy_hist[c] = busy;
            xfer = bus.out_valid && bus.out_ready;
            if (prev_stall && (!bus.out_valid || bus.data_out != prev_data)) stall_err++;
            if (bus.mem_rd) begin
                if (first_rd < 0) first_rd = c;
                if (bus.mem_addr != AW'(v.base + reads)) addr_err++;
                if ((reads - xfers - (xfer ? 1 : 0)) >= 2) space_err++;
                reads++;
            end
            if (bus.out_valid && first_val < 0) first_val = c;
            if (xfer) begin
                if (bus.data_out != word_of(v.base + xfers)) data_err++;
                xfers++;
                last_xfer = c;
            end
            if (done) begin
                done_n++;
                if (done_c < 0) done_c = c;
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data = bus.data_out;
            if ((done_c >= 0 && c >= done_c + 2) || c >= 150) break;
            @(posedge clk);
            #1;
            c++;
            start = (c == v.restart_c);
            if (c == v.restart_c) begin
                base_addr = AW'(10);
                length = (AW + 1)'(5);
            end
            bus.out_ready = ready_for(v.mode, c);
        end
        start = 1'b0;
        for (int k = 0; k <= c; k++) begin
            exp_busy = (v.len > 0) && (k >= 1) && (k <= last_xfer);
            if (busy_hist[k] != exp_busy) busy_err++;
        end
        chk({nm, ".words"}, xfers, v.len);
        chk({nm, ".reads"}, reads, v.len);
        chk({nm, ".first_rd_cycle"}, first_rd, (v.len > 0) ? 1 : -1);
        chk({nm, ".first_valid_cycle"}, first_val, v.exp_first);
        chk({nm, ".done_cycle"}, done_c, v.exp_done);
        chk({nm, ".done_pulses"}, done_n, 1);
        chk({nm, ".addr_errors"}, addr_err, 0);
        chk({nm, ".data_errors"}, data_err, 0);
        chk({nm, ".stall_errors"}, stall_err, 0);
        chk({nm, ".space_errors"}, space_err, 0);
        chk({nm, ".busy_errors"}, busy_err, 0);
        $display("burst %s: base=%0d len=%0d mode=%0d words=%0d reads=%0d first_valid=%0d done_at=%0d",
                 nm, v.base, v.len, v.mode, xfers, reads, first_val, done_c);
    endtask

    initial begin
        int c, xfers, n_done, n_valid, n_rd;
        logic seen;
        vec_t v;

        //            base len mode restart first done
        vecs[0] = '{0,  16, 0, -1,  3, 19};
        vecs[1] = '{14, 4,  0, -1,  3, 7};
        vecs[2] = '{3,  8,  1, -1,  3, 18};
        vecs[3] = '{5,  4,  2, -1,  3, 9};
        vecs[4] = '{9,  1,  0, -1,  3, 4};
        vecs[5] = '{7,  0,  0, -1, -1, 1};
        vecs[6] = '{2,  3,  0,  2,  3, 6};

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.mem_rd", int'(bus.mem_rd), 0);
        chk("reset.mem_addr", int'(bus.mem_addr), 0);
        chk("reset.out_valid", int'(bus.out_valid), 0);
        chk("reset.data_out", int'(bus.data_out), 0);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_burst(vecs[i], $sformatf("vec%0d", i));
        end

        // Start accepted in the done cycle.
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = AW'(0); length = (AW + 1)'(2); bus.out_ready = 1'b1;
        c = 0; seen = 1'b0;
        while (c < 20) begin
            @(posedge clk);
            #1;
            c++;
            if (done) begin
                seen = 1'b1;
                start = 1'b1; base_addr = AW'(8); length = (AW + 1)'(2);
                break;
            end
            start = 1'b0;
        end
        chk("restart.done_seen", int'(seen), 1);
        chk("restart.done_cycle", c, 5);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("restart.busy", int'(busy), 1);
        chk("restart.mem_rd", int'(bus.mem_rd), 1);
        chk("restart.mem_addr", int'(bus.mem_addr), 8);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk("restart.second_done", int'(seen), 1);
        $display("sequence restart_in_done: first done at cycle %0d, second burst from addr 8", c);

        // Reset after three words of a ten-word burst.
        @(posedge clk);
        #1;
        start = 1'b1; base_addr = AW'(0); length = (AW + 1)'(10); bus.out_ready = 1'b1;
        xfers = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) xfers++;
            if (xfers == 3) break;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        chk("midrst.words_before", xfers, 3);
        @(posedge clk);
        #1;
        start = 1'b0; rst = 1'b1; bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        chk("midrst.busy", int'(busy), 0);
        chk("midrst.done", int'(done), 0);
        chk("midrst.mem_rd", int'(bus.mem_rd), 0);
        chk("midrst.mem_addr", int'(bus.mem_addr), 0);
        chk("midrst.out_valid", int'(bus.out_valid), 0);
        chk("midrst.data_out", int'(bus.data_out), 0);
        n_done = 0; n_valid = 0; n_rd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) n_done++;
            if (bus.out_valid) n_valid++;
            if (bus.mem_rd) n_rd++;
        end
        chk("midrst.later_done", n_done, 0);
        chk("midrst.later_valid", n_valid, 0);
        chk("midrst.later_rd", n_rd, 0);
        $display("sequence mid_burst_reset: reset after %0d words, outputs idle afterwards", xfers);
        v = '{4, 3, 0, -1, 3, 6};
        run_burst(v, "post_rst");

`ifdef MEM_STREAM_READER_STAT_EN
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("stat.cleared", int'(word_count), 0);
        v = '{0, 5, 0, -1, 3, 8};
        run_burst(v, "stat_a");
        v = '{3, 7, 0, -1, 3, 10};
        run_burst(v, "stat_b");
        chk("stat.word_count", int'(word_count), 12);
        $display("sequence stat: word_count=%0d after bursts of 5 and 7", word_count);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
